regfile_scoreboard: RTL and testbench

//  Parametrised multi-read-port register file with an integrated pending-write scoreboard.

---
 rtl/regfile_scoreboard_if.sv | 27 ++
 rtl/regfile_scoreboard.sv | 62 ++++++
 tb/tb_regfile_scoreboard.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: ID read/issue, WB write and scoreboard status bundle for regfile_scoreboard.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic                     stall;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     flush;
    logic [ADDR_W:0]          pend_cnt;
    modport master (
        output rd_en, rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
        input  rd_data, rd_pending, stall, pend_cnt
    );
    modport slave (
        input  rd_en, rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
        output rd_data, rd_pending, stall, pend_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with pending-write scoreboard and stall.
// Define REGFILE_BYPASS_EN for WB-to-ID write-through forwarding of data and pending state.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [NUM_RD-1:0] pend_rd;
    logic              wr_ok;
    logic              iss_ok;
    assign wr_ok  = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
    assign iss_ok = bus.iss_en && !(ZERO_REG != 0 && bus.iss_addr == '0);
    // Issue is applied last so a same-cycle producer survives both flush and writeback.
    always_comb begin
        pend_nxt = bus.flush ? '0 : pend;
        if (bus.wr_en && !bus.flush) pend_nxt[bus.wr_addr] = 1'b0;
        if (iss_ok) pend_nxt[bus.iss_addr] = 1'b1;
        cnt_nxt = '0;
        for (int k = 0; k < DEPTH; k++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[k]};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
            pend <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
        end
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              z;
        logic              hit;
        assign a   = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign z   = ZERO_REG != 0 && a == '0;
        assign hit = BYPASS && rst_n && wr_ok && bus.wr_addr == a;
        assign bus.rd_data[i*DATA_W +: DATA_W] = z ? '0 : hit ? bus.wr_data : regs[a];
        // A forwarded write retires the producer unless a new one is issued to the same register.
        assign pend_rd[i] = !z && pend[a] && !(hit && !(bus.iss_en && bus.iss_addr == a));
    end
    assign bus.rd_pending = pend_rd;
    assign bus.stall      = |(bus.rd_en & pend_rd);
    assign bus.pend_cnt   = cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus randomized traffic checked every cycle
// against an array/bit-vector model of the register file and scoreboard.
module tb_regfile_scoreboard;
    localparam int DW = 32, AW = 5, NR = 3, DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   run_cmp = 1'b0;
    logic [DW-1:0]    mregs [DEPTH];
    logic [DEPTH-1:0] mpend;

    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus();
    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register array plus a pending bit per register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpend = '0;
            foreach (mregs[k]) mregs[k] = '0;
        end else begin
            if (bus.flush) mpend = '0;
            else if (bus.wr_en) mpend[bus.wr_addr] = 1'b0;
            if (bus.iss_en && bus.iss_addr != 0) mpend[bus.iss_addr] = 1'b1;
            if (bus.wr_en && bus.wr_addr != 0) mregs[bus.wr_addr] = bus.wr_data;
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] ep;
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          hit;
        if (run_cmp) begin
            for (int p = 0; p < NR; p++) begin
                a   = bus.rd_addr[p*AW +: AW];
                hit = BYP && rst_n && bus.wr_en && a != 0 && bus.wr_addr == a;
                ed  = (a == 0) ? '0 : hit ? bus.wr_data : mregs[a];
                ep[p] = (a != 0) && mpend[a] && !(hit && !(bus.iss_en && bus.iss_addr == a));
                chk($sformatf("rd_data%0d", p), bus.rd_data[p*DW +: DW], ed);
            end
            chk("rd_pending", bus.rd_pending, ep);
            chk("stall", bus.stall, |(bus.rd_en & ep));
            chk("pend_cnt", bus.pend_cnt, $countones(mpend));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en  = '0;
        bus.iss_en = 1'b0;
        bus.wr_en  = 1'b0;
        bus.flush  = 1'b0;
    endtask

    task automatic port(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        idle();
        bus.rd_addr  = '0;
        bus.iss_addr = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        #2;
        chk("rst_cnt", bus.pend_cnt, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_data", bus.rd_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_cmp = 1'b1;
        // write r5, then a dropped write to r0
        bus.wr_en = 1'b1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF; port(0, 5);
        cyc(); bus.wr_en = 1'b0;
        #2 chk("t2_r5", bus.rd_data[31:0], 32'hDEADBEEF);
        bus.wr_en = 1'b1; bus.wr_addr = 0; bus.wr_data = 32'h1234; port(0, 0);
        cyc(); bus.wr_en = 1'b0;
        #2 chk("t2_r0", bus.rd_data[31:0], 0);
        // issue r7, dependent read stalls until writeback
        bus.iss_en = 1'b1; bus.iss_addr = 7;
        cyc(); bus.iss_en = 1'b0; bus.rd_en = 3'b001; port(0, 7);
        #2 chk("t3_stall", bus.stall, 1);
        chk("t3_cnt", bus.pend_cnt, 1);
        bus.wr_en = 1'b1; bus.wr_addr = 7; bus.wr_data = 32'h55;
        #1 chk("t3_stall_wr", bus.stall, !BYP);
        cyc(); bus.wr_en = 1'b0;
        #2 chk("t3_stall_after", bus.stall, 0);
        chk("t3_data", bus.rd_data[31:0], 32'h55);
        chk("t3_cnt_after", bus.pend_cnt, 0);
        // r3 pending, then issue+write r3 together
        bus.rd_en = '0; bus.iss_en = 1'b1; bus.iss_addr = 3;
        cyc();
        bus.wr_en = 1'b1; bus.wr_addr = 3; bus.wr_data = 32'hAA; port(0, 3);
        cyc(); idle();
        #2 chk("t4_data", bus.rd_data[31:0], 32'hAA);
        chk("t4_pend", bus.rd_pending[0], 1);
        chk("t4_cnt", bus.pend_cnt, 1);
        // three issues, then flush with a same-cycle issue
        bus.flush = 1'b1;
        cyc(); bus.flush = 1'b0; bus.iss_en = 1'b1; bus.iss_addr = 1;
        cyc(); bus.iss_addr = 2;
        cyc(); bus.iss_addr = 4;
        cyc(); bus.iss_en = 1'b0;
        #2 chk("t5_cnt3", bus.pend_cnt, 3);
        bus.flush = 1'b1; bus.iss_en = 1'b1; bus.iss_addr = 9;
        cyc(); idle(); port(0, 9); port(1, 1); port(2, 2);
        #2 chk("t5_cnt1", bus.pend_cnt, 1);
        chk("t5_pend", bus.rd_pending, 3'b001);
        // all ports on pending r6
        bus.iss_en = 1'b1; bus.iss_addr = 6;
        cyc(); bus.iss_en = 1'b0; port(0, 6); port(1, 6); port(2, 6); bus.rd_en = 3'b010;
        #2 chk("t6_pend", bus.rd_pending, 3'b111);
        chk("t6_stall", bus.stall, 1);
        bus.rd_en = '0;
        #1 chk("t6_nostall", bus.stall, 0);
        // asynchronous reset mid-run
        bus.wr_en = 1'b1; bus.wr_addr = 8; bus.wr_data = 32'hCAFE0008;
        cyc(); bus.wr_en = 1'b0; port(0, 5); port(1, 8); port(2, 6); bus.rd_en = 3'b111;
        #1 chk("t1_pre_stall", bus.stall, 1);
        chk("t1_pre_cnt", bus.pend_cnt, 2);
        #1 rst_n = 1'b0;
        #1 chk("t1_data", bus.rd_data, 0);
        chk("t1_cnt", bus.pend_cnt, 0);
        chk("t1_stall", bus.stall, 0);
        cyc(); rst_n = 1'b1; idle();
        // fill the scoreboard; r0 issue is ignored, count tops out at 31
        bus.iss_en = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            bus.iss_addr = k[AW-1:0];
            cyc();
        end
        bus.iss_addr = 17;
        cyc(); bus.iss_en = 1'b0;
        #2 chk("full_cnt", bus.pend_cnt, 31);
        // randomized traffic
        repeat (3000) begin
            cyc();
            bus.rd_en = NR'($urandom);
            for (int p = 0; p < NR; p++) port(p, AW'($urandom_range(0, 7)));
            bus.iss_en   = $urandom_range(0, 2) == 0;
            bus.iss_addr = AW'($urandom_range(0, 7));
            bus.wr_en    = $urandom_range(0, 1) == 1;
            bus.wr_addr  = AW'($urandom_range(0, 7));
            bus.wr_data  = $urandom;
            bus.flush    = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        cyc(); idle();
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
